// File: rtl/logicnet_lut_neuron_pipe.sv
// Run-time programmable truth-table neuron: a 2^IN_BITS x OUT_BITS lookup table
// behind a two-stage valid/ready pipeline, filled with DEFAULT_OUT after every reset.
module logicnet_lut_neuron_pipe #(
    parameter int                  IN_BITS     = 6,
    parameter int                  OUT_BITS    = 2,
    parameter logic [OUT_BITS-1:0] DEFAULT_OUT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    input  logic                wr_en,
    input  logic [IN_BITS-1:0]  wr_addr,
    input  logic [OUT_BITS-1:0] wr_data,
    output logic                init_done
);

    localparam int                 DEPTH     = 1 << IN_BITS;
    localparam logic [IN_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    state_t              next_state;
    logic [IN_BITS-1:0]  cnt;
    logic [OUT_BITS-1:0] lut [DEPTH];
    logic                s1_valid;
    logic [IN_BITS-1:0]  s1_addr;
    logic                stall;
    logic                accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (state == INIT && cnt == LAST_ADDR) begin
            next_state = RUN;
        end
    end

    // in_ready is deliberately combinational from out_ready so a draining
    // downstream lets a new beat in on the same edge.
    always_comb begin
        init_done = (state == RUN);
        stall     = out_valid & ~out_ready;
        in_ready  = (state == RUN) & ~stall;
        accept    = in_valid & in_ready;
    end

    // Table has no reset; INIT overwrites every entry, external writes only in RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            lut[cnt] <= DEFAULT_OUT;
        end else if (wr_en) begin
            lut[wr_addr] <= wr_data;
        end
    end

    // Reading lut with a non-blocking capture gives read-first on collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            out_data  <= lut[s1_addr];
            s1_valid  <= accept;
            s1_addr   <= in_data;
        end
    end

endmodule

// File: tb/tb_logicnet_lut_neuron_pipe.sv
// Randomised and directed bench for logicnet_lut_neuron_pipe, checked against a
// transaction-level table model with an in-order queue of expected lookups.
module tb_logicnet_lut_neuron_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic       init_done;

    typedef struct {
        logic [5:0] addr;
        logic [1:0] val;
    } beat_t;

    int         total = 0;
    int         bad = 0;
    bit         running = 1'b0;
    logic [1:0] model [64];
    beat_t      exp_q [$];

    logicnet_lut_neuron_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [5:0] id, input logic ordy,
                                 input logic we, input logic [5:0] wa, input logic [1:0] wd);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        #1;
    endtask

    // Observe the handshakes that the coming edge will perform, then take the edge.
    task automatic step_cycle();
        beat_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rd_data", 32'(out_data), 32'(e.val));
            end
        end
        if (in_valid && in_ready) begin
            e.addr = in_data;
            e.val  = model[in_data];
            exp_q.push_back(e);
        end
        if (wr_en && running) begin
            model[wr_addr] = wr_data;
        end
        @(posedge clk);
    endtask

    task automatic reset_model();
        foreach (model[i]) model[i] = 2'b00;
        exp_q.delete();
    endtask

    // Releases reset and walks the 64-cycle init, writing into the table the whole time.
    task automatic run_init();
        reset_model();
        running   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'd0;
        out_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 6'b000001;
        wr_data   = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (i < 64) begin
                checkOutput("init_busy", 32'(init_done), 32'd0);
                checkOutput("init_in_ready", 32'(in_ready), 32'd0);
            end else begin
                checkOutput("init_done", 32'(init_done), 32'd1);
                checkOutput("run_in_ready", 32'(in_ready), 32'd1);
            end
        end
        in_valid = 1'b0;
        wr_en    = 1'b0;
        running  = 1'b1;
    endtask

    task automatic write_entry(input logic [5:0] a, input logic [1:0] d);
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, a, d);
        step_cycle();
    endtask

    task automatic lookup(input logic [5:0] a);
        applyStimulus(1'b1, a, 1'b1, 1'b0, 6'd0, 2'd0);
        step_cycle();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 2'd0);
            step_cycle();
            n++;
        end
        #1;
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [5:0] saddr [4];
        logic [1:0] sexp [4];
        logic       held_v;
        logic [1:0] held_d;
        bit         conflict;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_init_done", 32'(init_done), 32'd0);

        run_init();
        lookup(6'b101101);
        lookup(6'b000001);
        drain();

        $display("[TB] program and stream");
        write_entry(6'b000000, 2'b10);
        write_entry(6'b001000, 2'b01);
        write_entry(6'b010100, 2'b01);
        saddr = '{6'b000000, 6'b001000, 6'b010100, 6'b111111};
        sexp  = '{2'b10, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i < 4, saddr[i % 4], 1'b1, 1'b0, 6'd0, 2'd0);
            checkOutput("stream_valid", 32'(out_valid), 32'(i >= 2 && i <= 5));
            if (i >= 2 && i <= 5) checkOutput("stream_data", 32'(out_data), 32'(sexp[i-2]));
            step_cycle();
        end
        drain();

        $display("[TB] backpressure");
        for (int a = 40; a < 48; a++) write_entry(6'(a), 2'($urandom));
        held_v = 1'b0;
        held_d = 2'b00;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i < 10, 6'(40 + i % 8), !(i >= 4 && i < 9), 1'b0, 6'd0, 2'd0);
            if (i == 4) begin
                held_v = out_valid;
                held_d = out_data;
                checkOutput("bp_valid", 32'(out_valid), 32'd1);
            end
            if (i > 4 && i < 9) begin
                checkOutput("bp_hold_valid", 32'(out_valid), 32'(held_v));
                checkOutput("bp_hold_data", 32'(out_data), 32'(held_d));
            end
            if (i >= 4 && i < 9) checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            step_cycle();
        end
        drain();

        $display("[TB] read/write collision");
        write_entry(6'b000100, 2'b10);
        lookup(6'b000100);
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b1, 6'b000100, 2'b01);
        step_cycle();
        applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 2'd0);
        checkOutput("collide_old", 32'(out_data), 32'd2);
        step_cycle();
        lookup(6'b000100);
        drain();
        checkOutput("collide_model", 32'(model[6'b000100]), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom % 4) != 0, 6'($urandom), ($urandom % 4) != 0,
                          ($urandom % 3) == 0, 6'($urandom), 2'($urandom));
            checkOutput("rnd_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (wr_en) begin
                conflict = in_valid && in_ready && (in_data == wr_addr);
                foreach (exp_q[j]) if (exp_q[j].addr == wr_addr) conflict = 1'b1;
                if (conflict) wr_en = 1'b0;
            end
            step_cycle();
        end
        drain();

        $display("[TB] reset mid-stream");
        write_entry(6'b111111, 2'b11);
        lookup(6'b000000);
        lookup(6'b111111);
        applyStimulus(1'b1, 6'b001000, 1'b1, 1'b0, 6'd0, 2'd0);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_init_done", 32'(init_done), 32'd0);
        run_init();
        lookup(6'b000000);
        lookup(6'b001000);
        lookup(6'b010100);
        lookup(6'b111111);
        lookup(6'b000100);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/logicnet_lut_neuron_pipe.md
Name: logicnet_lut_neuron_pipe

Overview:
- Parametrised, pipelined, run-time-programmable truth-table neuron for the LogicNet binary-classification datapath.
- Replaces fixed combinational ROM neurons with a loadable table of 2^IN_BITS entries, each OUT_BITS wide.
- Carries a valid/ready stream so layers can be chained with backpressure.
- On reset, an internal init sequencer fills the table with DEFAULT_OUT; a write port then reprograms entries without resynthesis.

Parameters:
- IN_BITS, 6, neuron fan-in bits; table depth is 2^IN_BITS.
- OUT_BITS, 2, output activation width per entry.
- DEFAULT_OUT, 0, value written to every entry during INIT (OUT_BITS wide).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input activation vector valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  IN_BITS  input activation vector (table address).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_BITS  looked-up activation.
- wr_en  in  1  table write strobe.
- wr_addr  in  IN_BITS  table entry to write.
- wr_data  in  OUT_BITS  new entry value.
- init_done  out  1  table initialisation complete.

Behaviour:
- Reset (asynchronous assert, synchronous release): while rst_n=0, in_ready=0, out_valid=0, out_data=0, init_done=0, init counter=0, FSM=INIT, pipeline valid bits cleared. Table contents are not reset directly; INIT rewrites them.
- FSM INIT:
  - Each cycle writes DEFAULT_OUT to table[cnt] and increments cnt.
  - When cnt = 2^IN_BITS-1 is written, go to RUN.
  - INIT lasts exactly 2^IN_BITS cycles after the first rising edge with rst_n=1.
  - in_ready=0 and wr_en is ignored throughout INIT.
- FSM RUN:
  - init_done=1 (registered, rises on the same edge as the move to RUN).
  - FSM stays in RUN until reset.
- Pipeline, two registered stages:
  - S1 holds the address and a valid bit; S2 is the out_data/out_valid register.
  - stall = out_valid & ~out_ready.
  - in_ready = (FSM==RUN) & ~stall; this path is combinational from out_ready.
  - Accept occurs on an edge where in_valid & in_ready.
  - When not stalled: S2 <= {S1.valid, table[S1.addr]} and S1 <= {accept, in_data}.
  - When stalled: S1 and S2 hold.
  - Latency: data accepted at edge k is presented with out_valid=1 after edge k+1. Throughput is 1 per cycle with no bubbles.
  - out_data holds stable while out_valid & ~out_ready.
- Writes (RUN only):
  - On an edge with wr_en=1, table[wr_addr] <= wr_data.
  - Writes are independent of stall.
- Read/write collision: read-first. If S2 captures table[a] on the same edge that writes address a, S2 gets the old value; lookups accepted afterwards see the new value.
- Reset mid-operation:
  - Any in-flight lookup is discarded and out_valid drops immediately (asynchronous).
  - After release, a full INIT re-runs, so prior writes are lost.
- Address width: wr_addr and in_data span the full table; there is no out-of-range case.
- Implementation: the table is distributed RAM with one write port and one read port.

Test Plan:
- Reset/init (defaults): release rst_n -> in_ready=0 and init_done=0 for 64 cycles; init_done=1 after the 64th edge; lookup of any address, e.g. in_data=6'b101101, returns 2'b00.
- Program and stream: write table[6'b000000]=2'b10, table[6'b001000]=2'b01, table[6'b010100]=2'b01; stream addresses 000000, 001000, 010100, 111111 back-to-back with out_ready=1 -> outputs 10, 01, 01, 00 on consecutive cycles, each one cycle after its accept.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, out_data and out_valid held, no beats lost or duplicated after release; order preserved.
- Collision: with table[000100]=2'b10, accept in_data=000100 at edge k and write wr_addr=000100, wr_data=2'b01 at edge k+1 -> output 2'b10; the next lookup of 000100 returns 2'b01.
- Write during INIT: assert wr_en with wr_addr=000001, wr_data=2'b11 during INIT -> after init_done, lookup of 000001 returns DEFAULT_OUT (2'b00).
- Reset mid-stream: drop rst_n while out_valid=1 -> out_valid=0 and in_ready=0 immediately; after release, full 64-cycle INIT and all previously written entries read 2'b00.
